reg_wb_unit: RTL

REG_WB_UNIT -- requirements
Module: reg_wb_unit

---
 rtl/reg_wb_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_wb_unit.sv
// Writeback staging unit: a 2-entry in-order FIFO between the pipeline and the
// register-file write port, with pending-write hazard detection and forwarding.
module reg_wb_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_regwrite,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_src,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_mem,
  input  logic [31:0] in_pc,
  input  logic        wb_hold,
  output logic [4:0]  wt_reg,
  output logic [31:0] wt_d,
  output logic        RegWrite,
  input  logic [4:0]  chk_r1,
  input  logic [4:0]  chk_r2,
  output logic        haz1,
  output logic        haz2,
  output logic [31:0] fwd1_d,
  output logic [31:0] fwd2_d
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // slot0 is always the head; slot1 is only meaningful when count == 2
  entry_t     slot0, slot1;
  logic [1:0] count;

  entry_t     new_entry;
  logic       store;
  logic       enq;
  logic       deq;

  function automatic logic [31:0] format_load(input logic [2:0] funct3,
                                              input logic [31:0] mem);
    case (funct3)
      3'b000:  format_load = {{24{mem[7]}}, mem[7:0]};
      3'b001:  format_load = {{16{mem[15]}}, mem[15:0]};
      3'b100:  format_load = {24'd0, mem[7:0]};
      3'b101:  format_load = {16'd0, mem[15:0]};
      default: format_load = mem;
    endcase
  endfunction

  // Youngest match wins, so slot1 is checked before the head.
  function automatic logic [32:0] lookup(input logic [4:0] idx,
                                         input logic [1:0] cnt,
                                         input entry_t s0,
                                         input entry_t s1);
    lookup = 33'd0;
    if (idx != 5'd0) begin
      if (cnt == 2'd2 && s1.rd == idx)
        lookup = {1'b1, s1.data};
      else if (cnt != 2'd0 && s0.rd == idx)
        lookup = {1'b1, s0.data};
    end
  endfunction

  always_comb begin
    new_entry.rd = in_rd;
    case (in_src)
      2'b01:   new_entry.data = format_load(in_funct3, in_mem);
      2'b10:   new_entry.data = in_pc + 32'd4;
      default: new_entry.data = in_alu;
    endcase
    in_ready = (count != 2'd2);
    store    = in_regwrite && (in_rd != 5'd0) && (in_src != 2'b11);
    enq      = in_valid && in_ready && store;
    RegWrite = (count != 2'd0) && !wb_hold;
    deq      = RegWrite;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (enq && deq) begin
        // Only reachable at occupancy 1: the newcomer replaces the leaving head
        slot0 <= new_entry;
      end else if (deq) begin
        slot0 <= slot1;
        count <= count - 2'd1;
      end else if (enq) begin
        if (count == 2'd0)
          slot0 <= new_entry;
        else
          slot1 <= new_entry;
        count <= count + 2'd1;
      end
    end
  end

  always_comb begin
    wt_reg = (count != 2'd0) ? slot0.rd   : 5'd0;
    wt_d   = (count != 2'd0) ? slot0.data : 32'd0;
    {haz1, fwd1_d} = lookup(chk_r1, count, slot0, slot1);
    {haz2, fwd2_d} = lookup(chk_r2, count, slot0, slot1);
  end

endmodule
